// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: FSM states, the reset instruction word
// and the data-access width codes used by the decoder and memory interface.
package core_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [31:0] Nop = 32'h0000_0013;

  localparam logic [1:0] WidthByte = 2'b00;
  localparam logic [1:0] WidthHalf = 2'b01;
  localparam logic [1:0] WidthWord = 2'b10;

  // Only half and word accesses carry an alignment constraint.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (width)
      WidthWord: bad = (addr_lo != 2'b00);
      WidthHalf: bad = addr_lo[0];
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, execute, optional data access, write-back,
// sharing a single-port memory between instruction and data traffic.
module core_sequencer
  import core_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] CurrentPC,
  input  logic        RdMem,
  input  logic        WrMem,
  input  logic        Illegal,
  input  logic [31:0] DAddr,
  input  logic [31:0] WData,
  input  logic [1:0]  DWidth,
  output logic [31:0] Instruction,
  output logic [31:0] RData,
  output logic        PCEn,
  output logic        RegWrEn,
  output logic        Halted,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [1:0]  MemWidth,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic [31:0] InstRet
);

  state_e      state_q;
  logic [31:0] instr_q;
  logic [31:0] rdata_q;
  logic [31:0] instret_q;

  logic mem_op;
  logic bad_access;
  logic retire;

  assign mem_op     = RdMem | WrMem;
  assign bad_access = Illegal | (mem_op & misaligned(DWidth, DAddr[1:0]));

  // A retire is the cycle the PC register loads; it must coincide with the state that
  // completes the instruction so the next fetch already sees the new PC.
  always_comb begin
    retire = 1'b0;
    if (!reset) begin
      retire = ((state_q == StExec) && !bad_access && !mem_op) || (state_q == StWb);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFetch;
      instr_q   <= Nop;
      rdata_q   <= '0;
      instret_q <= '0;
    end else begin
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
      unique case (state_q)
        StFetch: begin
          if (MemAck) begin
            instr_q <= MemRData;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (bad_access) begin
            state_q <= StHalt;
          end else if (mem_op) begin
            state_q <= StMem;
          end else begin
            state_q <= StFetch;
          end
        end
        StMem: begin
          if (MemAck) begin
            if (RdMem) begin
              rdata_q <= MemRData;
            end
            state_q <= StWb;
          end
        end
        StWb:    state_q <= StFetch;
        StHalt:  state_q <= StHalt;
        default: state_q <= StHalt;
      endcase
    end
  end

  // Request fields depend only on state and the held decoder outputs, so they stay
  // stable for the whole wait period.
  always_comb begin
    MemReq   = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = CurrentPC;
    MemWData = '0;
    MemWidth = WidthWord;
    Halted   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StFetch: MemReq = 1'b1;
        StMem: begin
          MemReq   = 1'b1;
          MemWe    = WrMem;
          MemAddr  = DAddr;
          MemWData = WData;
          MemWidth = DWidth;
        end
        StHalt:  Halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign PCEn        = retire;
  assign RegWrEn     = retire;
  assign Instruction = instr_q;
  assign RData       = rdata_q;
  assign InstRet     = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: plays PC register, decoder and memory, and checks
// every cycle against a transaction-level expectation built from the sequencing rules.
module tb_core_sequencer;

  localparam logic [31:0] NopWord = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] CurrentPC;
  logic        RdMem, WrMem, Illegal;
  logic [31:0] DAddr, WData;
  logic [1:0]  DWidth;
  logic [31:0] Instruction, RData;
  logic        PCEn, RegWrEn, Halted;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic [1:0]  MemWidth;
  logic [31:0] MemRData;
  logic        MemAck;
  logic [31:0] InstRet;

  core_sequencer u_dut (
    .clock      (clock),
    .reset      (reset),
    .CurrentPC  (CurrentPC),
    .RdMem      (RdMem),
    .WrMem      (WrMem),
    .Illegal    (Illegal),
    .DAddr      (DAddr),
    .WData      (WData),
    .DWidth     (DWidth),
    .Instruction(Instruction),
    .RData      (RData),
    .PCEn       (PCEn),
    .RegWrEn    (RegWrEn),
    .Halted     (Halted),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemWidth   (MemWidth),
    .MemRData   (MemRData),
    .MemAck     (MemAck),
    .InstRet    (InstRet)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Expected outputs for the current cycle, set by the driver.
  logic        chk_en = 1'b0;
  logic        in_rst = 1'b0;
  logic        e_req, e_we, e_pcen, e_halt, e_data_phase;
  logic [31:0] e_addr, e_wdata;
  logic [1:0]  e_width;

  // Architectural model state.
  logic [31:0] pc, m_instret, m_instr, m_rdata;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check_eq("MemReq", 32'(MemReq), 32'(e_req));
      check_eq("MemWe", 32'(MemWe), 32'(e_we));
      check_eq("PCEn", 32'(PCEn), 32'(e_pcen));
      check_eq("Halted", 32'(Halted), 32'(e_halt));
      if (!in_rst) begin
        check_eq("RegWrEn", 32'(RegWrEn), 32'(e_pcen));
        check_eq("InstRet", InstRet, m_instret);
        check_eq("Instruction", Instruction, m_instr);
        check_eq("RData", RData, m_rdata);
        if (e_req) begin
          check_eq("MemAddr", MemAddr, e_addr);
          check_eq("MemWidth", 32'(MemWidth), 32'(e_width));
        end
        if (e_data_phase && e_we) check_eq("MemWData", MemWData, e_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    e_req = 1'b0; e_we = 1'b0; e_pcen = 1'b0; e_halt = 1'b0; e_data_phase = 1'b0;
  endtask

  task automatic retire_update();
    m_instret = m_instret + 32'd1;
    pc = pc + 32'd4;
    CurrentPC = pc;
  endtask

  task automatic do_reset();
    set_idle();
    in_rst = 1'b1;
    reset = 1'b1;
    MemAck = 1'($urandom % 2);
    tick();
    tick();
    reset = 1'b0;
    in_rst = 1'b0;
    MemAck = 1'b0;
    pc = 32'h0;
    CurrentPC = pc;
    m_instret = 32'h0;
    m_instr = NopWord;
    m_rdata = 32'h0;
  endtask

  task automatic fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i <= waits; i++) begin
      set_idle();
      e_req = 1'b1; e_addr = pc; e_width = 2'b10;
      // Decoder outputs are irrelevant while fetching.
      RdMem = 1'($urandom); WrMem = 1'($urandom); Illegal = 1'($urandom);
      DAddr = $urandom; WData = $urandom; DWidth = 2'($urandom);
      MemAck = (i == waits);
      MemRData = (i == waits) ? word : $urandom;
      tick();
    end
    MemAck = 1'b0;
    m_instr = word;
  endtask

  // Returns 0 for a plain retire, 1 for a data access, 2 for halt.
  task automatic exec(input logic rd, input logic wr, input logic ill, input logic [31:0] da,
                      input logic [1:0] dw, input logic [31:0] wd, output int outcome);
    int  size;
    logic misal;
    RdMem = rd; WrMem = wr; Illegal = ill; DAddr = da; DWidth = dw; WData = wd;
    size = 1 << dw;
    misal = (rd | wr) && ((int'(da[1:0]) % size) != 0);
    if (ill || misal) outcome = 2;
    else if (rd | wr) outcome = 1;
    else outcome = 0;
    set_idle();
    e_pcen = (outcome == 0);
    MemAck = 1'($urandom % 2);
    tick();
    MemAck = 1'b0;
    if (outcome == 0) retire_update();
  endtask

  task automatic mem_req_cycle(input logic ack, input logic [31:0] word);
    set_idle();
    e_req = 1'b1; e_we = WrMem; e_addr = DAddr; e_wdata = WData; e_width = DWidth;
    e_data_phase = 1'b1;
    MemAck = ack;
    MemRData = ack ? word : $urandom;
    tick();
    MemAck = 1'b0;
    if (ack && RdMem) m_rdata = word;
  endtask

  task automatic mem_phase(input int waits, input logic [31:0] word);
    for (int i = 0; i < waits; i++) mem_req_cycle(1'b0, 32'h0);
    mem_req_cycle(1'b1, word);
    set_idle();
    e_pcen = 1'b1;
    MemAck = 1'($urandom % 2);
    tick();
    MemAck = 1'b0;
    retire_update();
  endtask

  task automatic halt_phase(input int n);
    set_idle();
    e_halt = 1'b1;
    for (int i = 0; i < n; i++) begin
      MemAck = 1'($urandom % 2);
      tick();
    end
    MemAck = 1'b0;
  endtask

  initial begin
    int oc;
    reset = 1'b1; CurrentPC = '0; RdMem = 0; WrMem = 0; Illegal = 0;
    DAddr = '0; WData = '0; DWidth = 2'b10; MemRData = '0; MemAck = 0;
    set_idle();
    pc = 0; m_instret = 0; m_instr = NopWord; m_rdata = 0;
    chk_en = 1'b1;
    do_reset();
    #1;
    check_eq("reset InstRet", InstRet, 32'h0);
    check_eq("reset Instruction", Instruction, 32'h0000_0013);
    check_eq("reset RData", RData, 32'h0);
    check_eq("first MemReq", 32'(MemReq), 32'd1);

    // Zero-wait ADDI at PC 0.
    fetch(32'h0000_0013, 0);
    #1;
    check_eq("addi Instruction", Instruction, 32'h0000_0013);
    exec(1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0, oc);
    #1;
    check_eq("addi InstRet", InstRet, 32'd1);

    // LW from 0x100 with 3 wait states in both phases.
    fetch(32'h1000_2003, 3);
    exec(1'b1, 1'b0, 1'b0, 32'h100, 2'b10, 32'h0, oc);
    mem_phase(3, 32'hDEAD_BEEF);
    #1;
    check_eq("lw RData", RData, 32'hDEAD_BEEF);
    check_eq("lw InstRet", InstRet, 32'd2);

    // SH to 0x102 is aligned; SW to 0x102 halts.
    fetch(32'h0020_1123, 1);
    exec(1'b0, 1'b1, 1'b0, 32'h102, 2'b01, 32'hCAFE_1234, oc);
    mem_phase(1, 32'h0);
    fetch(32'h0020_2123, 0);
    exec(1'b0, 1'b1, 1'b0, 32'h102, 2'b10, 32'h1234_5678, oc);
    #1;
    check_eq("sw Halted", 32'(Halted), 32'd1);
    check_eq("sw MemReq", 32'(MemReq), 32'd0);
    halt_phase(5);
    do_reset();

    // Illegal instruction halts until reset.
    fetch(32'hFFFF_FFFF, 2);
    exec(1'b0, 1'b0, 1'b1, 32'h0, 2'b10, 32'h0, oc);
    halt_phase(20);
    do_reset();
    #1;
    check_eq("post-halt Halted", 32'(Halted), 32'd0);

    // Reset while the data phase is waiting.
    fetch(32'h0000_0013, 0);
    exec(1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0, oc);
    fetch(32'h1000_2003, 1);
    exec(1'b1, 1'b0, 1'b0, 32'h200, 2'b10, 32'h0, oc);
    mem_req_cycle(1'b0, 32'h0);
    mem_req_cycle(1'b0, 32'h0);
    do_reset();
    #1;
    check_eq("abort InstRet", InstRet, 32'h0);
    check_eq("abort MemAddr", MemAddr, 32'h0);

    // Counter wrap.
    force u_dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release u_dut.instret_q;
    m_instret = 32'hFFFF_FFFF;
    fetch(32'h0000_0013, 1);
    exec(1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0, oc);
    #1;
    check_eq("wrap InstRet", InstRet, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic rd, wr, ill;
      logic [31:0] da;
      logic [1:0] dw;
      rd  = (($urandom % 3) == 0);
      wr  = !rd && (($urandom % 3) == 0);
      ill = (($urandom % 12) == 0);
      da  = 32'h200 + ($urandom % 64);
      dw  = 2'($urandom % 3);
      fetch($urandom, int'($urandom % 4));
      exec(rd, wr, ill, da, dw, $urandom, oc);
      if (oc == 1) begin
        mem_phase(int'($urandom % 4), $urandom);
      end else if (oc == 2) begin
        halt_phase(2 + int'($urandom % 4));
        do_reset();
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
